soc_mini_chain_top: RTL and testbench
=====================================

# soc_mini_chain_top

Minimal SoC-level top used for board bring-up of a pure register-chain datapath. It samples the 8 active-low board switches through a 2-flop synchronizer and passes the inverted value down a `DEPTH`-stage register chain. The chain output drives `led[7:0]`. A parallel valid-bit chain drives `led[15:8]` as a fill indicator, so propagation through each stage is visible on the LEDs.

## Interface
- `DEPTH`, default 8: number of chain stages; legal range 1..8.
- `clk`, input, 1: single system clock; all flops on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset; clears every flop.
- `switch`, input, 8: board switches, active-low (switch on = 0); asynchronous to `clk`.
- `led`, output, 16: `[7:0]` is the last-stage data; `[15:8]` holds the per-stage valid flags.

## Operation
- Synchronizer:
  - `s1 <= ~switch`; `s2 <= s1`.
  - Valid companions: `sv1 <= 1`; `sv2 <= sv1`.
- Data chain:
  - `stage[0] <= s2`; `stage[i] <= stage[i-1]` for i = 1..DEPTH-1.
  - All stages are 8 bits wide.
- Valid chain:
  - `v[0] <= sv2`; `v[i] <= v[i-1]`.
  - Once set, the valid bits stay at 1 until reset.
- Outputs:
  - `led[7:0] = stage[DEPTH-1]`.
  - `led[8+i] = v[i]` for i < DEPTH.
  - `led[15:8+DEPTH]` is tied to 0.
- No enable and no stall: every flop updates on every rising edge while `resetn` = 1.
- The chain does no arithmetic; data passes bit-exact apart from the single inversion at the synchronizer input.
- Switch changes mid-chain: successive samples travel as independent wavefronts, one per cycle, with no merging.

## Timing
- Reset:
  - All data, valid and synchronizer flops clear asynchronously when `resetn` = 0.
  - `led` = 16'h0000 immediately, without waiting for a clock edge.
- Latency: a switch value sampled into `s1` at rising edge k appears on `led[7:0]` after edge k+DEPTH+1, i.e. DEPTH+2 cycles total (10 for DEPTH=8).
- Fill sequence:
  - After reset release, the first rising edge sets `sv1`.
  - `v[0]` sets after the 3rd edge, and `v[i]` after edge 3+i.
  - For DEPTH=8, `led[15:8]` steps 00 → 01 → 03 → 07 → … → FF, one step per cycle; it reaches FF after edge 10.
  - The data byte becomes valid in the same cycle that `led[15]` (`v[DEPTH-1]`) sets.
- Reset mid-operation: asynchronous clear of everything. After release the fill sequence restarts from 00 and no pre-reset data reappears.
- Reset release is synchronous to clock operation in the sense that the first capture happens on the first rising edge after `resetn` rises.
- `switch` is metastability-filtered only through `s1`/`s2`; no other input path exists.

## Configuration
- `LED_ACTIVE_LOW_EN`:
  - When defined, the whole `led` bus is driven inverted for active-low board LEDs. The reset value then becomes 16'hFFFF and a fully filled chain carrying 0x05 shows 16'h00FA.
  - When undefined, `led` is active-high exactly as described above.
  - Internal registers are identical in both builds; only the output inversion changes.

## Test plan
- Reset hold: `resetn`=0 with `switch`=8'hFA → `led` = 16'h0000 throughout, with no clock dependence.
- Fill and latency: `switch` = 8'hFA (value 0x05), release reset:
  - `led[15:8]` steps 01, 03, …, FF on edges 3..10.
  - `led[7:0]` = 0x00 until edge 10, then 0x05; final `led` = 16'hFF05.
- Wavefront: after fill, change `switch` from 8'hFA to 8'h00 → `led[7:0]` changes to 0xFF exactly 10 cycles later, and `led[15:8]` stays FF.
- Single-cycle pulse: drive `switch`=8'h7F for exactly one cycle (aligned to an edge), otherwise 8'hFF → `led[7:0]` shows 0x80 for exactly one cycle, 10 cycles later.
- Mid-operation reset: assert `resetn`=0 for 3 cycles while filled → `led` clears at once; after release the fill sequence repeats from 00.
- `DEPTH`=3 build: `led[15:11]` = 0 always; `led[10:8]` fills 1, 3, 7; data latency is 5 cycles.
- `LED_ACTIVE_LOW_EN` build: reset gives 16'hFFFF; after the fill with 0x05 input, `led` = 16'h00FA.

Source files
------------

// File: rtl/soc_mini_chain_top.sv
// Board bring-up top: synchronised, inverted switches travel down a DEPTH-stage
// register chain, with a parallel valid chain shown as a fill bar on led[15:8].
// Optional build macro: LED_ACTIVE_LOW_EN drives the whole led bus inverted.
`timescale 1ns/1ps

module soc_mini_chain_top #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  localparam int unsigned DW   = 8;
  localparam int unsigned LEDW = 16;

  logic [DW-1:0]    s1;
  logic [DW-1:0]    s2;
  logic             sv1;
  logic             sv2;
  logic [DW-1:0]    stage [DEPTH];
  logic             v     [DEPTH];
  logic [DEPTH-1:0] led_v;
  logic [LEDW-1:0]  led_c;

  // Two-flop synchronizer; the valid companion marks the first real sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1  <= '0;
      s2  <= '0;
      sv1 <= 1'b0;
      sv2 <= 1'b0;
    end else begin
      s1  <= ~switch;
      s2  <= s1;
      sv1 <= 1'b1;
      sv2 <= sv1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          stage[g] <= '0;
          v[g]     <= 1'b0;
        end else begin
          stage[g] <= s2;
          v[g]     <= sv2;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          stage[g] <= '0;
          v[g]     <= 1'b0;
        end else begin
          stage[g] <= stage[g-1];
          v[g]     <= v[g-1];
        end
      end
    end
    assign led_v[g] = v[g];
  end

  // Unused fill-bar positions above DEPTH are zero-extended.
  always_comb begin
    led_c = {8'(led_v), stage[DEPTH-1]};
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_c;
`else
  assign led = led_c;
`endif

endmodule

// File: tb/tb_soc_mini_chain_top.sv
// Self-checking bench for soc_mini_chain_top: DEPTH=8 and DEPTH=3 instances
// checked each cycle against a sample-history model plus literal spot checks.
`timescale 1ns/1ps

module tb_soc_mini_chain_top;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [15:0] led3;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Edge count since reset release and the switch value seen at each edge.
  int         n = 0;
  logic [7:0] hist [4096];

  soc_mini_chain_top #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .switch(switch), .led(led));

  soc_mini_chain_top #(.DEPTH(3)) dut3 (
    .clk(clk), .resetn(resetn), .switch(switch), .led(led3));

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) n = 0;
    else begin
      n = n + 1;
      hist[n] = switch;
    end
  end

  function automatic logic [15:0] board(input logic [15:0] x);
`ifdef LED_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  // After edge n: fill bar holds min(max(n-2,0),d) ones; data is the inverted
  // switch value captured d+1 edges earlier, or zero if none yet.
  function automatic logic [15:0] model_led(input int d, input int cnt);
    logic [15:0] r;
    int fill;
    r = '0;
    fill = cnt - 2;
    if (fill < 0) fill = 0;
    if (fill > d) fill = d;
    for (int i = 0; i < fill; i++) r[8+i] = 1'b1;
    if (cnt - (d + 1) >= 1) r[7:0] = ~hist[cnt-(d+1)];
    return board(r);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t, edges=%0d)", name, act, exp, $time, n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_d8", led,  model_led(8, n));
      check("model_d3", led3, model_led(3, n));
    end
  end

  initial begin
    resetn = 1'b0;
    switch = 8'hFA;
    #3;
    check("reset_no_clock_d8", led,  board(16'h0000));
    check("reset_no_clock_d3", led3, board(16'h0000));
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hold", led, board(16'h0000));

    // Fill with 0x05.
    resetn = 1'b1;
    @(negedge clk);
    check("fill_e1", led, board(16'h0000));
    repeat (2) @(negedge clk);
    check("fill_e3", led, board(16'h0100));
    @(negedge clk);
    check("fill_e4_d3", led3, board(16'h0300));
    @(negedge clk);
    check("fill_e5_d3", led3, board(16'h0705));
    repeat (4) @(negedge clk);
    check("fill_e9", led, board(16'h7F00));
    @(negedge clk);
    check("fill_e10", led, board(16'hFF05));
    check("fill_e10_d3", led3, board(16'h0705));

    // Wavefront: new value visible exactly 10 edges after its capture.
    switch = 8'h00;
    repeat (9) @(negedge clk);
    check("wave_before", led, board(16'hFF05));
    @(negedge clk);
    check("wave_after", led, board(16'hFFFF));

    // Single-cycle pulse.
    switch = 8'hFF;
    repeat (12) @(negedge clk);
    switch = 8'h7F;
    @(negedge clk);
    switch = 8'hFF;
    repeat (8) @(negedge clk);
    check("pulse_pre", led, board(16'hFF00));
    @(negedge clk);
    check("pulse_on", led, board(16'hFF80));
    @(negedge clk);
    check("pulse_off", led, board(16'hFF00));

    // Back-to-back distinct wavefronts, covered by the per-cycle model.
    for (int i = 0; i < 16; i++) begin
      switch = 8'(8'h11 * i + 8'h3);
      @(negedge clk);
    end
    switch = 8'hFA;
    repeat (12) @(negedge clk);
    check("refill_05", led, board(16'hFF05));

    // Mid-operation reset, asserted between edges.
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_clear_d8", led,  board(16'h0000));
    check("async_clear_d3", led3, board(16'h0000));
    repeat (3) @(negedge clk);
    switch = 8'hC3;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_e1", led, board(16'h0000));
    repeat (2) @(negedge clk);
    check("rst_e3", led, board(16'h0100));
    repeat (6) @(negedge clk);
    check("rst_e9", led, board(16'h7F00));
    @(negedge clk);
    check("rst_e10", led, board(16'hFF3C));
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
